conv3x3_engine: RTL
===================

// Module: conv3x3_engine
// PURPOSE
// Parametrised successor to the fixed 100x100 Gaussian data selector. Runs a 3x3 kernel over a
// frame held in an external sync-read RAM and writes each result to an output RAM, one pixel at
// a time in raster order. Adds:
//   - run-time mode select: passthrough, Gaussian, Laplacian edge detect
//   - start/busy/done handshake
//   - generic frame size and pixel width
// Sits between the frame-capture RAM (filled by the UART receive path) and the result RAM.
// PARAMETERS
// IMG_W   100  frame width in pixels (>=3)
// IMG_H   100  frame height in pixels (>=3)
// DATA_W  8    pixel width in bits
// ADDR_W  14   RAM address width; requires IMG_W*IMG_H <= 2**ADDR_W
// PORTS
// clk       in   1       single clock, all logic on rising edge
// rst_n     in   1       reset, asynchronous, active-low
// start     in   1       begin a frame pass; sampled only in IDLE
// mode      in   2       0 passthrough, 1 Gaussian, 2 Laplacian, 3 = passthrough; latched on start
// rd_addr   out  ADDR_W  source RAM read address
// rd_data   in   DATA_W  source RAM data; valid exactly 1 cycle after rd_addr
// wr_en     out  1       one-cycle write strobe to result RAM
// wr_addr   out  ADDR_W  result address = row*IMG_W + col
// wr_data   out  DATA_W  result pixel
// busy      out  1       high from the cycle after start until done
// done      out  1       one-cycle pulse after the last write
// BEHAVIOUR
// Reset: all outputs 0; FSM to IDLE; window regs, row, col, mode latch cleared. Reset is
//   asserted mid-frame: abort immediately, no further writes.
// FSM states:
//   IDLE   start=1 -> latch mode, row=col=0, busy=1 -> PIXEL
//   PIXEL  select path per pixel:
//     Border (row 0 / IMG_H-1 or col 0 / IMG_W-1), or any pixel in passthrough mode:
//       issue centre read -> WRITE data unchanged. 2 cycles/pixel.
//     Interior, col==1: FETCH all 9 taps, raster order (-W-1 .. +W+1), one read/cycle.
//     Interior, col>1: shift window left one column, FETCH 3 right-column taps
//       (-W+1, +1, +W+1).
//   FETCH  capture each rd_data into its window slot 1 cycle after its address.
//     Last capture -> CALC.
//   CALC   1 cycle -> WRITE.
//   WRITE  wr_en=1 for 1 cycle. Advance col; at IMG_W-1 wrap col=0, row+1.
//     After pixel (IMG_H-1, IMG_W-1) -> DONE.
//   DONE   done=1 and busy=0 for 1 cycle -> IDLE.
// Per-pixel cost:
//   border/passthrough  2 cycles
//   interior col==1     11 cycles (9 reads + capture + CALC)
//   interior col>1      5 cycles
//   No overlap between pixels.
// Arithmetic:
//   Gaussian   kernel 1 2 1 / 2 4 2 / 1 2 1; sum in DATA_W+4 bits; out = sum>>4 (truncate).
//   Laplacian  4*C - N - S - E - W; signed DATA_W+4 bits; clamp to [0, 2**DATA_W-1].
// Handshake and state:
//   start while busy is ignored. mode changes mid-frame have no effect.
//   rd_addr holds its last value when not reading.
//   wr_addr and wr_data hold after the write strobe.
// TESTING
// 1. IMG 4x4, all pixels 8'd80, mode 1 -> 16 writes, all wr_data=80; done 57 cycles after start.
// 2. 4x4, mode 2, centre (1,1)=200, rest 50 -> wr_data@5=255 (clamped 600); @6=0 (clamped -150).
// 3. 5x5 ramp pix=addr, mode 0 -> wr_data==wr_addr for all 25; no interior 11-cycle fetches.
// 4. 4x4, mode 1, start pulsed again while busy and mode switched to 2 mid-frame
//    -> single pass, Gaussian results, exactly one done.
// 5. rst_n low during FETCH of pixel (2,1) -> wr_en/busy/done=0 immediately;
//    next start re-runs from addr 0.
// 6. 100x100 impulse 255 at (50,50), mode 1 -> (50,50)=63, 4-neighbours=31,
//    diagonals=15, all else 0.

Source files
------------

// File: rtl/conv3x3_engine_if.sv
// Frame-pass bus for conv3x3_engine: start/mode command, busy/done status,
// source RAM read port and result RAM write port.
interface conv3x3_engine_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 14
);
    logic              start;
    logic [1:0]        mode;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              done;

    // Controller / RAM side
    modport master (
        output start, mode, rd_data,
        input  rd_addr, wr_en, wr_addr, wr_data, busy, done
    );

    // Engine side
    modport slave (
        input  start, mode, rd_data,
        output rd_addr, wr_en, wr_addr, wr_data, busy, done
    );
endinterface

// File: rtl/conv3x3_engine.sv
// 3x3 kernel engine: walks a frame in raster order from a sync-read source RAM and
// writes passthrough / Gaussian / Laplacian results to a result RAM, one pixel at a time.
module conv3x3_engine #(
    parameter int unsigned IMG_W  = 100,
    parameter int unsigned IMG_H  = 100,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    conv3x3_engine_if.slave  bus
);

    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);
    localparam int unsigned SUM_W = DATA_W + 4;
    localparam int unsigned TAP_W = 4;

    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0]  COL_ONE  = COL_W'(1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PIXEL,
        S_FETCH,
        S_CALC,
        S_WRITE,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [1:0]         r_mode;
    logic [ROW_W-1:0]   r_row;
    logic [COL_W-1:0]   r_col;
    logic [ADDR_W-1:0]  r_pix_addr;
    logic [TAP_W-1:0]   r_cnt;
    logic               r_full;
    logic [DATA_W-1:0]  r_win [0:8];

    logic [ADDR_W-1:0]  r_rd_addr;
    logic               r_wr_en;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [DATA_W-1:0]  r_wr_data;
    logic               r_busy;
    logic               r_done;

    logic [ROW_W-1:0]   w_nxt_row;
    logic [COL_W-1:0]   w_nxt_col;
    logic [ADDR_W-1:0]  w_nxt_addr;
    logic [1:0]         w_mode_eff;
    logic               w_nxt_simple;
    logic               w_last;
    logic               w_commit;
    logic               w_launch;
    logic [TAP_W-1:0]   w_n_taps;
    logic [TAP_W-1:0]   w_issue_k;
    logic [TAP_W-1:0]   w_cap_k;

    logic [SUM_W-1:0]        w_gsum;
    logic signed [SUM_W-1:0] w_lap;
    logic [DATA_W-1:0]       w_gauss;
    logic [DATA_W-1:0]       w_lap_clamp;
    logic [DATA_W-1:0]       w_kernel;

    assign bus.rd_addr = r_rd_addr;
    assign bus.wr_en   = r_wr_en;
    assign bus.wr_addr = r_wr_addr;
    assign bus.wr_data = r_wr_data;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;

    // Source address of window tap t (raster order -W-1 .. +W+1) around centre c
    function automatic logic [ADDR_W-1:0] f_tap_addr(input logic [ADDR_W-1:0] c,
                                                     input logic [TAP_W-1:0]  t);
        case (t)
            TAP_W'(0): f_tap_addr = c - ROW_STEP - ONE_A;
            TAP_W'(1): f_tap_addr = c - ROW_STEP;
            TAP_W'(2): f_tap_addr = c - ROW_STEP + ONE_A;
            TAP_W'(3): f_tap_addr = c - ONE_A;
            TAP_W'(5): f_tap_addr = c + ONE_A;
            TAP_W'(6): f_tap_addr = c + ROW_STEP - ONE_A;
            TAP_W'(7): f_tap_addr = c + ROW_STEP;
            TAP_W'(8): f_tap_addr = c + ROW_STEP + ONE_A;
            default:   f_tap_addr = c;
        endcase
    endfunction

    // k-th fetch of a pixel -> window slot; a partial fetch only refills the right column
    function automatic logic [TAP_W-1:0] f_tap_idx(input logic full, input logic [TAP_W-1:0] k);
        if (full) begin
            f_tap_idx = k;
        end else begin
            case (k)
                TAP_W'(0): f_tap_idx = TAP_W'(2);
                TAP_W'(1): f_tap_idx = TAP_W'(5);
                default:   f_tap_idx = TAP_W'(8);
            endcase
        end
    endfunction

    // Coordinates and path of the pixel about to be launched
    always_comb begin
        w_nxt_row  = r_row;
        w_nxt_col  = r_col + COL_ONE;
        w_nxt_addr = r_pix_addr + ONE_A;
        w_mode_eff = r_mode;
        if (r_state == S_IDLE) begin
            w_nxt_row  = '0;
            w_nxt_col  = '0;
            w_nxt_addr = '0;
            w_mode_eff = bus.mode;
        end else if (r_col == COL_LAST) begin
            w_nxt_row = r_row + ROW_W'(1);
            w_nxt_col = '0;
        end
        w_nxt_simple = (w_nxt_row == '0) || (w_nxt_row == ROW_LAST) ||
                       (w_nxt_col == '0) || (w_nxt_col == COL_LAST) ||
                       (w_mode_eff == 2'd0) || (w_mode_eff == 2'd3);
        w_last    = (r_row == ROW_LAST) && (r_col == COL_LAST);
        w_commit  = (r_state == S_WRITE) || (r_state == S_CALC);
        w_launch  = ((r_state == S_IDLE) && bus.start) || (w_commit && !w_last);
        w_n_taps  = r_full ? TAP_W'(9) : TAP_W'(3);
        w_issue_k = r_cnt + TAP_W'(1);
        w_cap_k   = r_cnt - TAP_W'(1);
    end

    // Gaussian 1-2-1 kernel and clamped 4-neighbour Laplacian over the window
    always_comb begin
        w_gsum = SUM_W'(r_win[0]) + SUM_W'(r_win[2]) + SUM_W'(r_win[6]) + SUM_W'(r_win[8]) +
                 ((SUM_W'(r_win[1]) + SUM_W'(r_win[3]) + SUM_W'(r_win[5]) + SUM_W'(r_win[7])) << 1) +
                 (SUM_W'(r_win[4]) << 2);
        w_gauss = DATA_W'(w_gsum >> 4);

        w_lap = $signed(SUM_W'(r_win[4]) << 2) - $signed(SUM_W'(r_win[1])) -
                $signed(SUM_W'(r_win[3])) - $signed(SUM_W'(r_win[5])) -
                $signed(SUM_W'(r_win[7]));
        if (w_lap[SUM_W-1]) begin
            w_lap_clamp = '0;
        end else if (|w_lap[SUM_W-2:DATA_W]) begin
            w_lap_clamp = '1;
        end else begin
            w_lap_clamp = w_lap[DATA_W-1:0];
        end

        w_kernel = (r_mode == 2'd2) ? w_lap_clamp : w_gauss;
    end

    // Frame-pass FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_mode     <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_pix_addr <= '0;
            r_cnt      <= '0;
            r_full     <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                r_win[i] <= '0;
            end
            r_rd_addr  <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            r_done  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_mode <= bus.mode;
                        r_busy <= 1'b1;
                    end
                end
                S_PIXEL: begin
                    r_state <= S_WRITE;
                end
                S_FETCH: begin
                    if (w_issue_k < w_n_taps) begin
                        r_rd_addr <= f_tap_addr(r_pix_addr, f_tap_idx(r_full, w_issue_k));
                    end
                    // Data lags its address by one cycle, so captures trail issues by one
                    if (r_cnt != '0) begin
                        r_win[f_tap_idx(r_full, w_cap_k)] <= bus.rd_data;
                    end
                    if (r_cnt == w_n_taps) begin
                        r_state <= S_CALC;
                    end else begin
                        r_cnt <= w_issue_k;
                    end
                end
                S_CALC, S_WRITE: begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= r_pix_addr;
                    r_wr_data <= (r_state == S_WRITE) ? bus.rd_data : w_kernel;
                    if (w_last) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // Launch the next pixel: first read address goes out on this edge
            if (w_launch) begin
                r_row      <= w_nxt_row;
                r_col      <= w_nxt_col;
                r_pix_addr <= w_nxt_addr;
                r_cnt      <= '0;
                if (w_nxt_simple) begin
                    r_rd_addr <= w_nxt_addr;
                    r_state   <= S_PIXEL;
                end else if (w_nxt_col == COL_ONE) begin
                    r_full    <= 1'b1;
                    r_rd_addr <= f_tap_addr(w_nxt_addr, TAP_W'(0));
                    r_state   <= S_FETCH;
                end else begin
                    r_full    <= 1'b0;
                    r_win[0]  <= r_win[1];
                    r_win[1]  <= r_win[2];
                    r_win[3]  <= r_win[4];
                    r_win[4]  <= r_win[5];
                    r_win[6]  <= r_win[7];
                    r_win[7]  <= r_win[8];
                    r_rd_addr <= f_tap_addr(w_nxt_addr, TAP_W'(2));
                    r_state   <= S_FETCH;
                end
            end
        end
    end

endmodule
